// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded RV32I fields into instruction words, rejects illegal
// immediates/encodings, and queues legal words in a small FIFO.
module instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_JALR = 7'h67;
  localparam logic [6:0] OP_S = 7'h23, OP_B = 7'h63, OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F;
  logic [31:0] word, i_word, held;
  logic legal, s12, s13, s21, accept, push, pop, bad;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  assign s12 = in_imm[31:11] == {21{in_imm[11]}};
  assign s13 = in_imm[31:12] == {20{in_imm[12]}};
  assign s21 = in_imm[31:20] == {12{in_imm[20]}};
  assign i_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
  always_comb begin
    legal = 1'b0;
    word = 32'd0;
    case (in_opcode)
      OP_R: begin
        legal = in_funct7 == 7'h00 || (in_funct7 == 7'h20 && (in_funct3 == 3'd0 || in_funct3 == 3'd5));
        word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_IMM: begin
        if (in_funct3 == 3'd1 || in_funct3 == 3'd5) begin
          legal = in_imm[31:5] == 27'd0 && (in_funct7 == 7'h00 || (in_funct7 == 7'h20 && in_funct3 == 3'd5));
          word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        end else begin
          legal = s12;
          word = i_word;
        end
      end
      OP_LOAD: begin
        legal = s12 && in_funct3 != 3'd3 && in_funct3 < 3'd6;
        word = i_word;
      end
      OP_JALR: begin
        legal = s12 && in_funct3 == 3'd0;
        word = i_word;
      end
      OP_S: begin
        legal = s12 && in_funct3 < 3'd3;
        word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      OP_B: begin
        legal = s13 && !in_imm[0] && in_funct3 != 3'd2 && in_funct3 != 3'd3;
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
      end
      OP_LUI, OP_AUIPC: begin
        legal = in_imm[11:0] == 12'd0;
        word = {in_imm[31:12], in_rd, in_opcode};
      end
      OP_JAL: begin
        legal = s21 && !in_imm[0];
        word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: begin
        legal = 1'b0;
        word = 32'd0;
      end
    endcase
  end
  assign in_ready = cnt != FULL;
  assign out_valid = cnt != '0;
  // An empty FIFO keeps presenting the last word that was popped.
  assign out_instr = out_valid ? mem[rd_ptr] : held;
  assign accept = in_valid && in_ready;
  assign push = accept && legal;
  assign bad = accept && !legal;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      held <= 32'd0;
      err_pulse <= 1'b0;
      err_sticky <= 1'b0;
      ok_count <= '0;
      err_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) held <= mem[rd_ptr];
      err_pulse <= bad;
      err_sticky <= err_sticky | bad;
      ok_count <= ok_count + CNT_W'(push && ok_count != '1);
      err_count <= err_count + CNT_W'(bad && err_count != '1);
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: randomized and directed checks of instruction_encoder against an
// arithmetic reference model with a queue-based FIFO scoreboard.
module tb_instruction_encoder;
  localparam int DEPTH = 4;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;
  } req_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, err_pulse, err_sticky;
  logic [6:0] in_opcode, in_funct7;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [2:0] in_funct3;
  logic [31:0] in_imm, out_instr;
  logic [CW-1:0] ok_count, err_count;
  int passed = 0, total = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_m;
  int ok_m, err_m;
  logic sticky_m, pulse_m, fired_m;

  instruction_encoder #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
    req_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  // Reference: legality from signed ranges and field placement by shift-and-or arithmetic.
  function automatic void ref_enc(input req_t r, output logic lg, output logic [31:0] w);
    int s;
    logic [31:0] base, im;
    s = r.imm;
    im = r.imm;
    base = 32'(r.op) | (32'(r.rd) << 7) | (32'(r.f3) << 12) | (32'(r.rs1) << 15);
    lg = 1'b0;
    w = 32'd0;
    if (r.op == 7'h33) begin
      lg = r.f7 == 0 || (r.f7 == 7'h20 && (r.f3 == 0 || r.f3 == 5));
      w = base | (32'(r.rs2) << 20) | (32'(r.f7) << 25);
    end else if (r.op == 7'h13 && (r.f3 == 1 || r.f3 == 5)) begin
      lg = im < 32 && (r.f7 == 0 || (r.f7 == 7'h20 && r.f3 == 5));
      w = base | (im << 20) | (32'(r.f7) << 25);
    end else if (r.op == 7'h13 || r.op == 7'h03 || r.op == 7'h67) begin
      lg = s >= -2048 && s <= 2047;
      if (r.op == 7'h03) lg = lg && (r.f3 <= 2 || r.f3 == 4 || r.f3 == 5);
      if (r.op == 7'h67) lg = lg && r.f3 == 0;
      w = base | ((im & 32'hFFF) << 20);
    end else if (r.op == 7'h23) begin
      lg = s >= -2048 && s <= 2047 && r.f3 <= 2;
      w = 32'(r.op) | (32'(r.f3) << 12) | (32'(r.rs1) << 15) | (32'(r.rs2) << 20)
        | ((im & 32'h1F) << 7) | (((im >> 5) & 32'h7F) << 25);
    end else if (r.op == 7'h63) begin
      lg = s >= -4096 && s <= 4095 && s % 2 == 0 && r.f3 != 2 && r.f3 != 3;
      w = 32'(r.op) | (32'(r.f3) << 12) | (32'(r.rs1) << 15) | (32'(r.rs2) << 20)
        | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7)
        | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
    end else if (r.op == 7'h37 || r.op == 7'h17) begin
      lg = im % 4096 == 0;
      w = 32'(r.op) | (32'(r.rd) << 7) | (im & 32'hFFFFF000);
    end else if (r.op == 7'h6F) begin
      lg = s >= -1048576 && s <= 1048575 && s % 2 == 0;
      w = 32'(r.op) | (32'(r.rd) << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
        | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
    end
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    logic [6:0] ops [10];
    int edges [10];
    ops = '{7'h33, 7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    edges = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 1048574, 1048576, -1048576};
    r.op = ($urandom_range(11) == 0) ? 7'($urandom) : ops[$urandom_range(9)];
    r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.f3 = 3'($urandom);
    case ($urandom_range(2))
      0: r.f7 = 7'h00;
      1: r.f7 = 7'h20;
      default: r.f7 = 7'($urandom);
    endcase
    case ($urandom_range(5))
      0: r.imm = $urandom;
      1: r.imm = 32'($urandom_range(8191)) - 32'd4096;
      2: r.imm = (32'($urandom_range(4194303)) - 32'd2097152) & ~32'd1;
      3: r.imm = $urandom & 32'hFFFFF000;
      4: r.imm = 32'($urandom_range(40));
      default: r.imm = 32'(edges[$urandom_range(9)]);
    endcase
    return r;
  endfunction

  function automatic req_t rnd_legal();
    req_t r;
    logic lg;
    logic [31:0] w;
    for (int i = 0; i < 1000; i++) begin
      r = rnd_req();
      ref_enc(r, lg, w);
      if (lg) return r;
    end
    return mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_m = 32'd0; ok_m = 0; err_m = 0; sticky_m = 1'b0; pulse_m = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one cycle from a negedge to the next and advances the model across the posedge.
  task automatic cyc(input logic v, input req_t r, input logic ordy);
    logic lg;
    logic [31:0] w;
    in_valid = v; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm; out_ready = ordy;
    ref_enc(r, lg, w);
    fired_m = v && exp_q.size() < DEPTH;
    if (ordy && exp_q.size() > 0) last_m = exp_q.pop_front();
    if (fired_m && lg) begin
      exp_q.push_back(w);
      if (ok_m < MAXC) ok_m++;
    end
    if (fired_m && !lg && err_m < MAXC) err_m++;
    pulse_m = fired_m && !lg;
    sticky_m = sticky_m | pulse_m;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_instr !== 32'd0) $display("FAIL reset_out_instr: got %h expected 0", out_instr); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if ({err_pulse, err_sticky} !== 2'b00) $display("FAIL reset_err: got %b expected 00", {err_pulse, err_sticky}); else passed++;
    total++; if (ok_count !== '0 || err_count !== '0) $display("FAIL reset_counts: got %0d/%0d expected 0/0", ok_count, err_count); else passed++;
  endtask

  task automatic test_vectors();
    req_t v [8];
    logic [31:0] e [8];
    v[0] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF); e[0] = 32'hFFF00093;
    v[1] = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);        e[1] = 32'h402081B3;
    v[2] = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8);        e[2] = 32'h00208463;
    v[3] = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);     e[3] = 32'h001000EF;
    v[4] = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000); e[4] = 32'h123452B7;
    v[5] = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFFFFC); e[5] = 32'hFE20AE23;
    v[6] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047);     e[6] = 32'h7FF00093;
    v[7] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800); e[7] = 32'h80000093;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, v[i], 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_instr !== e[i])
        $display("FAIL vector%0d: got valid=%b instr=%h expected valid=1 instr=%h", i, out_valid, out_instr, e[i]);
      else passed++;
    end
    cyc(1'b0, v[0], 1'b1);
    total++;
    if (out_valid !== 1'b0 || out_instr !== e[7])
      $display("FAIL empty_hold: got valid=%b instr=%h expected valid=0 instr=%h", out_valid, out_instr, e[7]);
    else passed++;
    total++; if (ok_count !== 4'd8) $display("FAIL vector_ok_count: got %0d expected 8", ok_count); else passed++;
  endtask

  task automatic test_illegal();
    do_reset();
    cyc(1'b1, mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048), 1'b1);
    total++; if (err_pulse !== 1'b1) $display("FAIL illegal_pulse: got %b expected 1", err_pulse); else passed++;
    total++; if (err_count !== 4'd1) $display("FAIL illegal_err_count: got %0d expected 1", err_count); else passed++;
    total++; if (err_sticky !== 1'b1) $display("FAIL illegal_sticky: got %b expected 1", err_sticky); else passed++;
    total++; if (out_valid !== 1'b0 || ok_count !== '0) $display("FAIL illegal_no_push: got valid=%b ok=%0d expected 0/0", out_valid, ok_count); else passed++;
    cyc(1'b0, mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0), 1'b1);
    total++; if (err_pulse !== 1'b0 || err_sticky !== 1'b1) $display("FAIL pulse_one_cycle: got pulse=%b sticky=%b expected 0/1", err_pulse, err_sticky); else passed++;
    cyc(1'b1, mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3), 1'b1);
    total++; if (err_count !== 4'd2 || err_pulse !== 1'b1) $display("FAIL beq_odd: got cnt=%0d pulse=%b expected 2/1", err_count, err_pulse); else passed++;
    cyc(1'b1, mk(7'h7F, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0), 1'b1);
    total++; if (err_count !== 4'd3 || out_valid !== 1'b0) $display("FAIL bad_opcode: got cnt=%0d valid=%b expected 3/0", err_count, out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    req_t r [5];
    logic sent;
    do_reset();
    for (int i = 0; i < 5; i++) r[i] = rnd_legal();
    for (int i = 0; i < 4; i++) cyc(1'b1, r[i], 1'b0);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full: got in_ready=%b expected 0", in_ready); else passed++;
    for (int i = 0; i < 2; i++) cyc(1'b1, r[4], 1'b0);
    total++; if (ok_count !== 4'd4 || in_ready !== 1'b0) $display("FAIL bp_held: got ok=%0d in_ready=%b expected 4/0", ok_count, in_ready); else passed++;
    total++; if (out_instr !== exp_q[0]) $display("FAIL bp_head_stable: got %h expected %h", out_instr, exp_q[0]); else passed++;
    sent = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(!sent, r[4], 1'b1);
      sent = sent | fired_m;
      total++;
      if (in_ready !== (exp_q.size() < DEPTH) || out_valid !== (exp_q.size() > 0))
        $display("FAIL bp_flags%0d: got ready=%b valid=%b expected %b/%b", k, in_ready, out_valid, exp_q.size() < DEPTH, exp_q.size() > 0);
      else passed++;
      total++;
      if (out_instr !== (exp_q.size() > 0 ? exp_q[0] : last_m))
        $display("FAIL bp_order%0d: got %h expected %h", k, out_instr, exp_q.size() > 0 ? exp_q[0] : last_m);
      else passed++;
    end
    total++; if (ok_count !== 4'd5) $display("FAIL bp_total: got %0d expected 5", ok_count); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_legal(), 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(1'b1, rnd_legal(), 1'b1);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_instr !== exp_q[0] || exp_q.size() != 3)
        $display("FAIL b2b%0d: got valid=%b ready=%b instr=%h expected 1/1/%h", i, out_valid, in_ready, out_instr, exp_q[0]);
      else passed++;
    end
    cyc(1'b1, rnd_legal(), 1'b0);
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_full: got in_ready=%b expected 0", in_ready); else passed++;
    cyc(1'b1, rnd_legal(), 1'b1);
    total++;
    if (in_ready !== 1'b1 || out_instr !== exp_q[0])
      $display("FAIL full_push_pop: got ready=%b instr=%h expected 1/%h", in_ready, out_instr, exp_q[0]);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    req_t r;
    logic lg;
    logic [31:0] w;
    do_reset();
    cyc(1'b1, mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_legal(), 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_reset_flags: got valid=%b ready=%b expected 0/1", out_valid, in_ready); else passed++;
    total++; if (ok_count !== '0 || err_count !== '0 || err_sticky !== 1'b0) $display("FAIL mid_reset_counts: got %0d/%0d/%b expected 0/0/0", ok_count, err_count, err_sticky); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    r = rnd_legal();
    ref_enc(r, lg, w);
    cyc(1'b1, r, 1'b1);
    total++; if (out_valid !== 1'b1 || out_instr !== w) $display("FAIL mid_reset_first: got valid=%b instr=%h expected 1/%h", out_valid, out_instr, w); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, rnd_legal(), 1'b1);
    total++; if (ok_count !== 4'd15) $display("FAIL ok_saturate: got %0d expected 15", ok_count); else passed++;
    for (int i = 0; i < 18; i++) cyc(1'b1, mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0), 1'b1);
    total++; if (err_count !== 4'd15) $display("FAIL err_saturate: got %0d expected 15", err_count); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(3) != 0, rnd_req(), $urandom_range(2) != 0);
      total++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < DEPTH))
        $display("FAIL rnd_flags%0d: got valid=%b ready=%b expected %b/%b", i, out_valid, in_ready, exp_q.size() > 0, exp_q.size() < DEPTH);
      else passed++;
      total++;
      if (out_instr !== (exp_q.size() > 0 ? exp_q[0] : last_m))
        $display("FAIL rnd_instr%0d: got %h expected %h", i, out_instr, exp_q.size() > 0 ? exp_q[0] : last_m);
      else passed++;
      total++;
      if (err_pulse !== pulse_m || err_sticky !== sticky_m)
        $display("FAIL rnd_err%0d: got pulse=%b sticky=%b expected %b/%b", i, err_pulse, err_sticky, pulse_m, sticky_m);
      else passed++;
      total++;
      if (ok_count !== CW'(ok_m) || err_count !== CW'(err_m))
        $display("FAIL rnd_counts%0d: got %0d/%0d expected %0d/%0d", i, ok_count, err_count, ok_m, err_m);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    model_reset();
    test_reset();
    test_vectors();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
